// File: rtl/div_rs_scheduler_pkg.sv
// Shared types and constants for the divider reservation station.
// Carries the CDB broadcast packet plus the default RS depth and ROB tag width.
// Imported by every file of the scheduler slice.
package div_rs_scheduler_pkg;

  localparam int RS_DEPTH  = 4;
  localparam int ROB_TAG_W = 4;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] dest_ROB_entry;
    logic [XLEN-1:0]      result;
  } CDB_packet_t;

endpackage

// File: rtl/div_rs_scheduler_age_picker.sv
// Oldest-request picker: grants the requesting entry with the smallest age rank.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own ready.
module age_picker #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]               req,
  input  logic [DEPTH*$clog2(DEPTH)-1:0] ranks,
  output logic [DEPTH-1:0]               grant,
  output logic                           found
);

  localparam int RW = $clog2(DEPTH);

  // Ranks of valid entries are unique, so exactly one requester has no older rival.
  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && req[j] && (ranks[j*RW +: RW] < ranks[i*RW +: RW])) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

  assign found = |req;

endmodule

// File: rtl/div_rs_scheduler.sv
// Divider reservation station: holds instructions until both operands arrive, issues oldest-ready.
// Latency: an entry allocated with ready operands issues one cycle later; a CDB wakeup adds one cycle.
// Backpressure: alloc_ready drops when all entries are held; issue waits for fu_ready.
module div_rs_scheduler
  import div_rs_scheduler_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [ROB_TAG_W-1:0]       alloc_rob,
  input  logic                       alloc_op,
  input  logic                       alloc_a_rdy,
  input  logic                       alloc_b_rdy,
  input  logic [XLEN-1:0]            alloc_a_val,
  input  logic [XLEN-1:0]            alloc_b_val,
  input  logic [ROB_TAG_W-1:0]       alloc_a_tag,
  input  logic [ROB_TAG_W-1:0]       alloc_b_tag,
  input  logic                       cdb_valid,
  input  CDB_packet_t                cdb,
  output logic                       fu_valid_in,
  input  logic                       fu_ready,
  output logic [ROB_TAG_W-1:0]       fu_rob,
  output logic                       fu_op,
  output logic [XLEN-1:0]            fu_dividend,
  output logic [XLEN-1:0]            fu_divisor,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  logic [DEPTH-1:0]     valid_q, op_q, a_rdy_q, b_rdy_q;
  logic [ROB_TAG_W-1:0] rob_q   [DEPTH];
  logic [ROB_TAG_W-1:0] a_tag_q [DEPTH];
  logic [ROB_TAG_W-1:0] b_tag_q [DEPTH];
  logic [XLEN-1:0]      a_val_q [DEPTH];
  logic [XLEN-1:0]      b_val_q [DEPTH];
  logic [IW-1:0]        rank_q  [DEPTH];

  logic [DEPTH-1:0]    eligible, grant;
  logic [DEPTH*IW-1:0] ranks_flat;
  logic                pick_found, issue, alloc_fire, a_hit, b_hit;
  logic [IW-1:0]       sel_idx, free_idx, sel_rank, new_rank;
  logic [OW-1:0]       occ_after;

  // Count held entries; this drives both occupancy and the allocation gate.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OW'(valid_q[i]);
    end
  end

  assign alloc_ready = (occupancy < OW'(DEPTH));

  // Eligibility uses registered ready flags only, so a wakeup issues no earlier than next cycle.
  always_comb begin
    eligible   = valid_q & a_rdy_q & b_rdy_q;
    ranks_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ranks_flat[i*IW +: IW] = rank_q[i];
    end
  end

  age_picker #(.DEPTH(DEPTH)) u_picker (
    .req   (eligible),
    .ranks (ranks_flat),
    .grant (grant),
    .found (pick_found)
  );

  // Encode the one-hot grant and locate the lowest free slot for allocation.
  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel_idx = IW'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  assign issue       = fu_ready && pick_found && !flush;
  assign fu_valid_in = issue;
  assign fu_rob      = rob_q[sel_idx];
  assign fu_op       = op_q[sel_idx];
  assign fu_dividend = a_val_q[sel_idx];
  assign fu_divisor  = b_val_q[sel_idx];

  // Gate allocation on pre-issue fullness; the newcomer ranks behind everything that stays.
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign sel_rank   = rank_q[sel_idx];
  assign occ_after  = occupancy - OW'(issue);
  assign new_rank   = occ_after[IW-1:0];
  assign a_hit      = cdb_valid && (alloc_a_tag == cdb.dest_ROB_entry);
  assign b_hit      = cdb_valid && (alloc_b_tag == cdb.dest_ROB_entry);

  // Control state: valid bits, age ranks with compaction, and operand ready flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) rank_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue && grant[i]) begin
          valid_q[i] <= 1'b0;
        end else if (issue && valid_q[i] && (rank_q[i] > sel_rank)) begin
          rank_q[i] <= rank_q[i] - IW'(1);
        end
        if (valid_q[i] && cdb_valid && !a_rdy_q[i] && (a_tag_q[i] == cdb.dest_ROB_entry)) begin
          a_rdy_q[i] <= 1'b1;
        end
        if (valid_q[i] && cdb_valid && !b_rdy_q[i] && (b_tag_q[i] == cdb.dest_ROB_entry)) begin
          b_rdy_q[i] <= 1'b1;
        end
      end
      if (alloc_fire) begin
        valid_q[free_idx] <= 1'b1;
        rank_q[free_idx]  <= new_rank;
        a_rdy_q[free_idx] <= alloc_a_rdy || a_hit;
        b_rdy_q[free_idx] <= alloc_b_rdy || b_hit;
      end
    end
  end

  // Payload registers: captured on allocation or wakeup, never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cdb_valid && !a_rdy_q[i] && (a_tag_q[i] == cdb.dest_ROB_entry)) begin
        a_val_q[i] <= cdb.result;
      end
      if (valid_q[i] && cdb_valid && !b_rdy_q[i] && (b_tag_q[i] == cdb.dest_ROB_entry)) begin
        b_val_q[i] <= cdb.result;
      end
    end
    if (alloc_fire) begin
      rob_q[free_idx]   <= alloc_rob;
      op_q[free_idx]    <= alloc_op;
      a_tag_q[free_idx] <= alloc_a_tag;
      b_tag_q[free_idx] <= alloc_b_tag;
      a_val_q[free_idx] <= alloc_a_rdy ? alloc_a_val : cdb.result;
      b_val_q[free_idx] <= alloc_b_rdy ? alloc_b_val : cdb.result;
    end
  end

endmodule

// File: tb/tb_div_rs_scheduler.sv
// Directed bench for div_rs_scheduler with an age-ordered queue model checked every cycle.
// Latency: inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Backpressure: fu_ready and fill level are driven directly by the scenarios.
module tb_div_rs_scheduler;
  import div_rs_scheduler_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, alloc_valid, alloc_ready, alloc_op;
  logic [3:0]  alloc_rob, alloc_a_tag, alloc_b_tag;
  logic        alloc_a_rdy, alloc_b_rdy;
  logic [31:0] alloc_a_val, alloc_b_val;
  logic        cdb_valid;
  CDB_packet_t cdb;
  logic        fu_valid_in, fu_ready, fu_op;
  logic [3:0]  fu_rob;
  logic [31:0] fu_dividend, fu_divisor;
  logic [2:0]  occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  div_rs_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .alloc_op(alloc_op), .alloc_a_rdy(alloc_a_rdy), .alloc_b_rdy(alloc_b_rdy),
    .alloc_a_val(alloc_a_val), .alloc_b_val(alloc_b_val),
    .alloc_a_tag(alloc_a_tag), .alloc_b_tag(alloc_b_tag),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .fu_valid_in(fu_valid_in), .fu_ready(fu_ready), .fu_rob(fu_rob), .fu_op(fu_op),
    .fu_dividend(fu_dividend), .fu_divisor(fu_divisor), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries kept in age order, oldest at the front.
  typedef struct {
    logic [3:0]  rob;
    logic        op;
    logic        a_rdy, b_rdy;
    logic [31:0] a_val, b_val;
    logic [3:0]  a_tag, b_tag;
  } ment_t;

  ment_t mq[$];
  bit    started = 1'b0;

  // Compare DUT outputs to the model, then advance the model to the next edge.
  always @(negedge clk) begin : model
    int    e;
    bit    exp_ar, exp_fv;
    ment_t n;
    e = -1; exp_ar = 1'b0; exp_fv = 1'b0;
    if (started) begin
      foreach (mq[i]) if (e < 0 && mq[i].a_rdy && mq[i].b_rdy) e = i;
      exp_ar = (mq.size() < DEPTH);
      exp_fv = fu_ready && (e >= 0) && !flush;
      chk("model occupancy", 32'(occupancy), 32'(mq.size()));
      chk("model alloc_ready", 32'(alloc_ready), 32'(exp_ar));
      chk("model fu_valid_in", 32'(fu_valid_in), 32'(exp_fv));
      if (exp_fv) begin
        chk("model fu_rob", 32'(fu_rob), 32'(mq[e].rob));
        chk("model fu_op", 32'(fu_op), 32'(mq[e].op));
        chk("model fu_dividend", fu_dividend, mq[e].a_val);
        chk("model fu_divisor", fu_divisor, mq[e].b_val);
      end
    end
    if (reset) begin
      mq.delete();
      started = 1'b1;
    end else if (started) begin
      if (flush) begin
        mq.delete();
      end else begin
        foreach (mq[i]) begin
          if (cdb_valid && !mq[i].a_rdy && mq[i].a_tag == cdb.dest_ROB_entry) begin
            mq[i].a_rdy = 1'b1; mq[i].a_val = cdb.result;
          end
          if (cdb_valid && !mq[i].b_rdy && mq[i].b_tag == cdb.dest_ROB_entry) begin
            mq[i].b_rdy = 1'b1; mq[i].b_val = cdb.result;
          end
        end
        if (exp_fv) mq.delete(e);
        if (alloc_valid && exp_ar) begin
          n.rob = alloc_rob; n.op = alloc_op;
          n.a_tag = alloc_a_tag; n.b_tag = alloc_b_tag;
          n.a_rdy = alloc_a_rdy; n.a_val = alloc_a_val;
          n.b_rdy = alloc_b_rdy; n.b_val = alloc_b_val;
          if (!alloc_a_rdy && cdb_valid && alloc_a_tag == cdb.dest_ROB_entry) begin
            n.a_rdy = 1'b1; n.a_val = cdb.result;
          end
          if (!alloc_b_rdy && cdb_valid && alloc_b_tag == cdb.dest_ROB_entry) begin
            n.b_rdy = 1'b1; n.b_val = cdb.result;
          end
          mq.push_back(n);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_alloc(input logic [3:0] rob, input logic op,
                           input logic ar, input logic [31:0] av, input logic [3:0] at,
                           input logic br, input logic [31:0] bv, input logic [3:0] bt);
    alloc_valid = 1'b1; alloc_rob = rob; alloc_op = op;
    alloc_a_rdy = ar; alloc_a_val = av; alloc_a_tag = at;
    alloc_b_rdy = br; alloc_b_val = bv; alloc_b_tag = bt;
  endtask

  task automatic set_cdb(input logic v, input logic [3:0] tag, input logic [31:0] res);
    cdb_valid = v; cdb.dest_ROB_entry = tag; cdb.result = res;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; fu_ready = 1'b0;
    alloc_valid = 1'b0; alloc_rob = '0; alloc_op = 1'b0;
    alloc_a_rdy = 1'b0; alloc_b_rdy = 1'b0; alloc_a_val = '0; alloc_b_val = '0;
    alloc_a_tag = '0; alloc_b_tag = '0;
    set_cdb(1'b0, 4'd0, 32'd0);
    tick(); tick();
    reset = 1'b0;
    sample();
    chk("reset occupancy", 32'(occupancy), 32'd0);
    chk("reset alloc_ready", 32'(alloc_ready), 32'd1);
    chk("reset fu_valid_in", 32'(fu_valid_in), 32'd0);

    // Both operands ready: 100 / 3 issues one cycle after allocation.
    tick();
    fu_ready = 1'b1;
    set_alloc(4'd1, 1'b1, 1'b1, 32'd100, 4'd0, 1'b1, 32'd3, 4'd0);
    sample();
    chk("s1 no issue in alloc cycle", 32'(fu_valid_in), 32'd0);
    tick();
    alloc_valid = 1'b0;
    sample();
    chk("s1 fu_valid_in", 32'(fu_valid_in), 32'd1);
    chk("s1 fu_dividend", fu_dividend, 32'd100);
    chk("s1 fu_divisor", fu_divisor, 32'd3);
    chk("s1 fu_rob", 32'(fu_rob), 32'd1);
    tick();
    sample();
    chk("s1 occupancy drained", 32'(occupancy), 32'd0);

    // A waits on tag 5, younger B is ready and issues first; A follows a cycle after wakeup.
    tick();
    set_alloc(4'd2, 1'b1, 1'b0, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0);
    tick();
    set_alloc(4'd3, 1'b0, 1'b1, 32'd50, 4'd0, 1'b1, 32'd5, 4'd0);
    tick();
    alloc_valid = 1'b0;
    sample();
    chk("s2 B issues first", 32'(fu_rob), 32'd3);
    tick();
    set_cdb(1'b1, 4'd5, 32'd7);
    sample();
    chk("s2 no issue on wakeup cycle", 32'(fu_valid_in), 32'd0);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0);
    sample();
    chk("s2 A issues", 32'(fu_valid_in), 32'd1);
    chk("s2 A rob", 32'(fu_rob), 32'd2);
    chk("s2 A dividend", fu_dividend, 32'd7);

    // Same-cycle bypass: tag 9 on the CDB while allocating.
    tick();
    set_alloc(4'd4, 1'b1, 1'b0, 32'd0, 4'd9, 1'b1, 32'd6, 4'd0);
    set_cdb(1'b1, 4'd9, 32'd42);
    tick();
    alloc_valid = 1'b0;
    set_cdb(1'b0, 4'd0, 32'd0);
    sample();
    chk("s3 bypass issue", 32'(fu_valid_in), 32'd1);
    chk("s3 bypass dividend", fu_dividend, 32'd42);

    // Fill to capacity, then issue and allocate together.
    tick();
    fu_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(4'(i), 1'b1, 1'b1, 32'(10 + i), 4'd0, 1'b1, 32'd1, 4'd0);
      tick();
    end
    alloc_valid = 1'b0;
    sample();
    chk("s4 full alloc_ready", 32'(alloc_ready), 32'd0);
    chk("s4 full occupancy", 32'(occupancy), 32'd4);
    tick();
    fu_ready = 1'b1;
    set_alloc(4'd5, 1'b0, 1'b1, 32'd99, 4'd0, 1'b1, 32'd9, 4'd0);
    sample();
    chk("s4 oldest issues", 32'(fu_rob), 32'd0);
    chk("s4 refused while full", 32'(alloc_ready), 32'd0);
    tick();
    sample();
    chk("s4 occupancy after issue", 32'(occupancy), 32'd3);
    chk("s4 accepts next cycle", 32'(alloc_ready), 32'd1);
    tick();
    alloc_valid = 1'b0;
    sample();
    chk("s4 occupancy held", 32'(occupancy), 32'd3);
    for (int i = 0; i < 4; i++) tick();
    sample();
    chk("s4 drained", 32'(occupancy), 32'd0);

    // Flush with two eligible entries.
    tick();
    fu_ready = 1'b0;
    set_alloc(4'd6, 1'b1, 1'b1, 32'd8, 4'd0, 1'b1, 32'd2, 4'd0);
    tick();
    set_alloc(4'd7, 1'b1, 1'b1, 32'd9, 4'd0, 1'b1, 32'd3, 4'd0);
    tick();
    alloc_valid = 1'b0;
    fu_ready = 1'b1;
    flush = 1'b1;
    sample();
    chk("s5 flush suppresses issue", 32'(fu_valid_in), 32'd0);
    tick();
    flush = 1'b0;
    sample();
    chk("s5 occupancy after flush", 32'(occupancy), 32'd0);
    chk("s5 alloc_ready after flush", 32'(alloc_ready), 32'd1);

    // Reset with three waiting entries, then a stale CDB match.
    tick();
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_alloc(4'(8 + i), 1'b1, 1'b0, 32'd0, 4'd11, 1'b1, 32'd4, 4'd0);
      tick();
    end
    alloc_valid = 1'b0;
    sample();
    chk("s6 held before reset", 32'(occupancy), 32'd3);
    tick();
    reset = 1'b1;
    fu_ready = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    chk("s6 occupancy after reset", 32'(occupancy), 32'd0);
    chk("s6 fu_valid_in after reset", 32'(fu_valid_in), 32'd0);
    tick();
    set_cdb(1'b1, 4'd11, 32'd5);
    tick();
    set_cdb(1'b0, 4'd0, 32'd0);
    sample();
    chk("s6 stale cdb occupancy", 32'(occupancy), 32'd0);
    chk("s6 stale cdb no issue", 32'(fu_valid_in), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
